dac_ser: RTL and testbench

Serializes the delayed, inverted count word and its frame-enable toggle into a 3-wire serial stream (data, clock, sync) plus a latch strobe for the off-chip/analog DAC. It sits directly downstream of the digital top's delay stage. A new frame starts on every change of the enable toggle, i.e. once per counter loop. The captured word is shifted MSB-first, and one latch pulse is issued after the last bit.

---
 rtl/dac_ser_pkg.sv | 19 +
 rtl/dac_ser_bit_timer.sv | 41 ++++
 rtl/dac_ser.sv | 121 ++++++++++++
 tb/tb_dac_ser.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ser_pkg.sv
// Shared types and helpers for the dac_ser serializer.
// Frame length depends on DAC_SER_PARITY_EN (adds one even-parity bit).
package dac_ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  function automatic int unsigned frame_bits(input int unsigned width);
`ifdef DAC_SER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/dac_ser_bit_timer.sv
// Per-bit timer: counts 0..DIV-1 while enabled, giving the sclk phase and an
// end-of-bit strobe.
module dac_ser_bit_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase,
  output logic bit_done
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);
  localparam logic [CntW-1:0] Half = CntW'(DIV / 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // sclk low for the first half of the bit, high for the second
  assign phase    = (cnt_q >= Half);
  assign bit_done = en && !clr && (cnt_q == Last);

endmodule

// File: rtl/dac_ser.sv
// Serializer for the off-chip DAC: each enable toggle sends one MSB-first frame
// followed by a latch pulse. Optional even parity bit with DAC_SER_PARITY_EN.
module dac_ser
  import dac_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_i,
  input  logic             enable_i,
  input  logic             clr_ovr_i,
  output logic             sdata_o,
  output logic             sclk_o,
  output logic             sync_o,
  output logic             latch_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int unsigned FrameBits = frame_bits(WIDTH);
  localparam int unsigned BcW       = $clog2(FrameBits + 1);
  localparam logic [BcW-1:0] LastBit = BcW'(FrameBits - 1);

  state_e               state_q, state_d;
  logic                 enable_q;
  logic [FrameBits-1:0] sreg_q, sreg_d;
  logic [BcW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 trigger;
  logic                 phase, bit_done;
  logic [FrameBits-1:0] frame_word;

  assign trigger = enable_i ^ enable_q;

`ifdef DAC_SER_PARITY_EN
  assign frame_word = {code_i, ^code_i};
`else
  assign frame_word = code_i;
`endif

  dac_ser_bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == SHIFT),
    .clr      (state_q != SHIFT),
    .phase    (phase),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    sdata_o   = 1'b0;
    sclk_o    = 1'b0;
    sync_o    = 1'b0;
    latch_o   = 1'b0;
    busy_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          sreg_d    = frame_word;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sync_o  = 1'b1;
        busy_o  = 1'b1;
        sdata_o = sreg_q[FrameBits-1];
        sclk_o  = phase;
        if (bit_done) begin
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        latch_o = 1'b1;
        busy_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A trigger outside IDLE is dropped; flagging it takes priority over a clear
  always_comb begin
    overrun_d = overrun_q;
    if (trigger && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_ovr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_i;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_dac_ser.sv
// Directed self-checking bench for dac_ser (WIDTH=8, DIV=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dac_ser;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV   = 4;
`ifdef DAC_SER_PARITY_EN
  localparam int unsigned FB = WIDTH + 1;
`else
  localparam int unsigned FB = WIDTH;
`endif
  localparam int FL = FB * DIV;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] code_i;
  logic             enable_i;
  logic             clr_ovr_i;
  logic             sdata_o, sclk_o, sync_o, latch_o, busy_o, overrun_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_ser #(
    .WIDTH(WIDTH),
    .DIV  (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_i    (code_i),
    .enable_i  (enable_i),
    .clr_ovr_i (clr_ovr_i),
    .sdata_o   (sdata_o),
    .sclk_o    (sclk_o),
    .sync_o    (sync_o),
    .latch_o   (latch_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  // Toggles enable_i at the current falling edge and checks one whole frame.
  // Optional in-frame actions at sample index i: toggle, clear, code change.
  task automatic frame(input string name, input logic [7:0] code, input int toggle_at,
                       input int clr_at, input int change_at);
    logic [FB-1:0] ef;
    logic          exp_bit, exp_sclk, prev_sclk;
    int            data_err, sclk_err, rises, sync_cnt, busy_cnt, latch_cnt, latch_idx;
`ifdef DAC_SER_PARITY_EN
    ef = {code, ^code};
`else
    ef = code;
`endif
    data_err = 0; sclk_err = 0; rises = 0; sync_cnt = 0; busy_cnt = 0;
    latch_cnt = 0; latch_idx = -1; prev_sclk = 1'b0;
    enable_i = ~enable_i;
    code_i   = code;
    for (int i = 0; i <= FL + 1; i++) begin
      @(negedge clk);
      if (i < FL) begin
        exp_bit  = ef[FB - 1 - i / DIV];
        exp_sclk = (i % DIV) >= (DIV / 2);
      end else begin
        exp_bit  = 1'b0;
        exp_sclk = 1'b0;
      end
      if (sdata_o !== exp_bit) data_err++;
      if (sclk_o !== exp_sclk) sclk_err++;
      if (sclk_o === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = sclk_o;
      if (sync_o === 1'b1) sync_cnt++;
      if (busy_o === 1'b1) busy_cnt++;
      if (latch_o === 1'b1) begin
        latch_cnt++;
        latch_idx = i;
      end
      if (i == change_at) code_i = ~code;
      if (i == toggle_at) enable_i = ~enable_i;
      clr_ovr_i = (i == clr_at);
    end
    clr_ovr_i = 1'b0;
    checks++;
    if (data_err !== 0) begin
      errors++;
      $display("FAIL %s sdata: %0d wrong samples, required 0", name, data_err);
    end
    checks++;
    if (sclk_err !== 0) begin
      errors++;
      $display("FAIL %s sclk: %0d wrong samples, required 0", name, sclk_err);
    end
    checks++;
    if (rises !== FB) begin
      errors++;
      $display("FAIL %s sclk_rises: got %0d, required %0d", name, rises, FB);
    end
    checks++;
    if (sync_cnt !== FL) begin
      errors++;
      $display("FAIL %s sync_len: got %0d, required %0d", name, sync_cnt, FL);
    end
    checks++;
    if (busy_cnt !== FL + 1) begin
      errors++;
      $display("FAIL %s busy_len: got %0d, required %0d", name, busy_cnt, FL + 1);
    end
    checks++;
    if (latch_cnt !== 1 || latch_idx !== FL) begin
      errors++;
      $display("FAIL %s latch: %0d pulses at index %0d, required 1 at %0d", name, latch_cnt,
               latch_idx, FL);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_i = 1'b0; code_i = '0; clr_ovr_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sdata_o, sclk_o, sync_o, latch_o, busy_o, overrun_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {sdata_o, sclk_o, sync_o, latch_o, busy_o, overrun_o});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sync_o, busy_o, overrun_o} !== 3'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b, required 000", {sync_o, busy_o, overrun_o});
    end
  endtask

  task automatic test_basic();
    frame("rise_a5", 8'hA5, -1, -1, -1);
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL rise_a5 overrun: got %b, required 0", overrun_o);
    end
  endtask

  task automatic test_falling();
    frame("fall_3c", 8'h3C, -1, -1, -1);
    checks++;
    if (enable_i !== 1'b0 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL fall_3c state: enable %b overrun %b, required 0 0", enable_i, overrun_o);
    end
  endtask

  task automatic test_overrun();
    // code_i also changes mid-frame; the captured word must be unaffected
    frame("ovr_5a", 8'h5A, 10, -1, 3);
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got %b, required 1", overrun_o);
    end
    frame("ovr_set_vs_clr", 8'hC3, 12, 12, -1);
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins: got %b, required 1", overrun_o);
    end
    clr_ovr_i = 1'b1;
    @(negedge clk);
    clr_ovr_i = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b, required 0", overrun_o);
    end
  endtask

  task automatic test_latch_toggle();
    frame("latch_tog", 8'h81, FL, -1, -1);
    checks++;
    if (overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL latch_tog overrun: got %b, required 1", overrun_o);
    end
    // now in the first IDLE cycle after LATCH
    frame("idle_tog_66", 8'h66, -1, -1, -1);
    clr_ovr_i = 1'b1;
    @(negedge clk);
    clr_ovr_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int latch_seen, busy_seen;
    enable_i = ~enable_i;
    code_i   = 8'hFF;
    for (int i = 0; i <= 4 * DIV + 1; i++) @(negedge clk);
    checks++;
    if (sync_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_running: sync got %b, required 1", sync_o);
    end
    rst      = 1'b1;
    enable_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({sdata_o, sclk_o, sync_o, latch_o, busy_o, overrun_o} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b, required 000000",
               {sdata_o, sclk_o, sync_o, latch_o, busy_o, overrun_o});
    end
    rst = 1'b0;
    latch_seen = 0;
    busy_seen  = 0;
    for (int i = 0; i < FL + 4; i++) begin
      @(negedge clk);
      if (latch_o !== 1'b0) latch_seen++;
      if (busy_o !== 1'b0) busy_seen++;
    end
    checks++;
    if (latch_seen !== 0 || busy_seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_no_latch: latch %0d busy %0d cycles, required 0 0", latch_seen,
               busy_seen);
    end
  endtask

`ifdef DAC_SER_PARITY_EN
  task automatic test_parity();
    frame("parity_07", 8'h07, -1, -1, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_falling();
    test_overrun();
    test_latch_toggle();
    test_reset_mid();
`ifdef DAC_SER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
